wr_base_sched: RTL and testbench
================================

# wr_base_sched

Write-side frame-buffer scheduler for the VDMA. It owns the five one-hot frame-buffer pointers for the writer. On every write-frame start it picks the next buffer to write, and it publishes the last fully written buffer as `last_next_point`. The read-side base loop latches `last_next_point` on its own vsync. The block never hands the writer the buffer the reader currently holds, nor the newest complete frame.

## Interface
- `CNT_W`, 16: width of the frame and drop statistics counters.
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `en`  in  1  scheduler enable; low forces IDLE.
- `wr_vsync`  in  1  write-side frame sync, level; a frame starts on its rising edge.
- `buf_mask`  in  5  one bit per buffer; 1 = buffer usable.
- `rd_lock`  in  5  buffer(s) the reader is using, already synchronized to `clk`. Every set bit is excluded; all-zero means the reader is idle.
- `wr_curr_point`  out  5  one-hot buffer the writer is filling.
- `last_next_point`  out  5  one-hot, most recently completed frame.
- `frame_done`  out  1  one-cycle pulse when a frame is committed.
- `frame_drop`  out  1  one-cycle pulse when no free buffer exists and the frame is overwritten.
- `frame_cnt`  out  CNT_W  committed frames, wraps.
- `drop_cnt`  out  CNT_W  dropped frames, saturates at all-ones.

## Operation
- **Edge detect:** `vs_q <= wr_vsync`, `vs_qq <= vs_q`, `rise = vs_q & ~vs_qq`. Both registers reset to 0.
- **States:** IDLE, WRITE, ADVANCE.
- **IDLE:**
  - On `rise && en`, go to WRITE.
  - No pointer change and no count. This first frame goes into the current `wr_curr_point`.
- **WRITE:**
  - On `rise`, go to ADVANCE.
  - On `!en`, go to IDLE. `!en` has priority over `rise`.
- **ADVANCE** (exactly one cycle, then WRITE):
  - Candidate set = `buf_mask & ~rd_lock & ~last_next_point & ~wr_curr_point`, all sampled in this cycle.
  - Search is round-robin, starting at the bit above `wr_curr_point`'s set bit and wrapping 4→0.
  - **Candidate found:**
    - `last_next_point <= wr_curr_point`.
    - `wr_curr_point <=` the chosen bit.
    - `frame_cnt` increments.
    - `frame_done` pulses.
  - **No candidate:**
    - Both pointers hold.
    - `drop_cnt` increments, saturating.
    - `frame_drop` pulses.
  - `en` low during ADVANCE still completes the commit, then the FSM goes to IDLE.
- Pointers and counters are held in IDLE; only `rst` clears them.
- `rst` mid-frame or mid-ADVANCE aborts with no commit and restores all reset values.

## Timing
Reset values:
- `wr_curr_point` = 5'b00001
- `last_next_point` = 5'b00010 (matches the reader's reset pointer)
- `frame_done` = 0, `frame_drop` = 0
- `frame_cnt` = 0, `drop_cnt` = 0
- state IDLE

Latency and pulses:
- `wr_vsync` first sampled high at edge k: `rise` is true in cycle k→k+1, and the FSM enters ADVANCE at edge k+1.
- Pointers, counters and pulses update at edge k+2, two cycles after the first sample.
- `frame_done` and `frame_drop` are high for exactly the cycle after edge k+2.
- A second `rise` cannot occur during ADVANCE, since `vs_qq` is 1 there; no queuing is needed.
- A `wr_vsync` pulse shorter than one clock may be missed; that is the source's responsibility.

## Structure
- Package `vdma_sched_pkg`:
  - state enum (IDLE, WRITE, ADVANCE)
  - `NBUF` = 5
  - reset constants `WR_PTR_RST` = 5'b00001 and `RD_PTR_RST` = 5'b00010
- Sub-module `buf_pick_rr`: purely combinational.
  - Inputs: 5-bit candidate vector and one-hot start pointer.
  - Outputs: one-hot pick and a `found` flag.
  - Rotate, priority-encode, rotate back.
- The top holds the edge detect, FSM, pointer registers and counters.

## Test plan
- **Reset/idle:** assert `rst` with `wr_vsync` toggling, then release with `en`=0.
  - Required: pointers stay 00001/00010, counters 0, no pulses.
- **Steady rotation:** `en`=1, `buf_mask`=11111, `rd_lock`=00010, three `wr_vsync` rises.
  - First rise: IDLE→WRITE, no change.
  - Second rise: `wr_curr` 00001→00100, `last_next` 00001, `frame_cnt`=1.
  - Third rise: `wr_curr` 01000, `last_next` 00100, `frame_cnt`=2.
- **Wrap-around:** state `wr_curr`=10000, `last_next`=01000, `rd_lock`=00100, `buf_mask`=11111; next rise.
  - Required: `wr_curr` 00001, `last_next` 10000, checked 2 cycles after the first high sample.
- **Drop:** `buf_mask`=00111, `wr_curr`=00001, `last_next`=00010, `rd_lock`=00100; rise.
  - Required: pointers unchanged, `frame_drop` pulses once, `drop_cnt`=1.
  - Preload `drop_cnt` to all-ones via forced drops: it stays saturated.
- **Mid-operation events:**
  - `rst` asserted in the ADVANCE cycle: no commit, reset values next edge.
  - `en` dropped in the same cycle as a `rise` in WRITE: IDLE, no commit.
  - `en` dropped during ADVANCE: commit happens, then IDLE.

Source files
------------

// File: rtl/vdma_sched_pkg.sv
// Shared types and constants for the VDMA write-side buffer scheduler.
package vdma_sched_pkg;

    localparam int unsigned NBUF = 5;

    localparam logic [NBUF-1:0] WR_PTR_RST = 5'b00001;
    // Matches the reader's reset pointer so the two sides agree out of reset.
    localparam logic [NBUF-1:0] RD_PTR_RST = 5'b00010;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRITE,
        ST_ADVANCE
    } sched_state_e;

    function automatic int unsigned onehot_idx(input logic [NBUF-1:0] v);
        int unsigned idx;
        idx = 0;
        for (int unsigned i = 0; i < NBUF; i++) begin
            if (v[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/buf_pick_rr.sv
// Round-robin buffer picker: first candidate strictly above the start pointer,
// wrapping from the top buffer back to buffer 0.
module buf_pick_rr
    import vdma_sched_pkg::*;
(
    input  logic [NBUF-1:0] cand,
    input  logic [NBUF-1:0] start,
    output logic [NBUF-1:0] pick,
    output logic            found
);

    logic [2*NBUF-1:0] rot_dbl;
    logic [2*NBUF-1:0] back_dbl;
    logic [NBUF-1:0]   rot;
    logic [NBUF-1:0]   sel_rot;
    int unsigned       sh;

    always_comb begin
        sh      = onehot_idx(start) + 1;
        // Rotate so the bit above start lands at position 0, encode, rotate back.
        rot_dbl = {cand, cand} >> sh;
        rot     = rot_dbl[NBUF-1:0];
        sel_rot = '0;
        found   = 1'b0;
        for (int unsigned i = 0; i < NBUF; i++) begin
            if (!found && rot[i]) begin
                sel_rot[i] = 1'b1;
                found      = 1'b1;
            end
        end
        back_dbl = {sel_rot, sel_rot} << sh;
        pick     = back_dbl[2*NBUF-1:NBUF];
    end

endmodule

// File: rtl/wr_base_sched.sv
// Write-side frame-buffer scheduler: picks the next write buffer on each frame
// start and publishes the most recently completed buffer to the reader.
module wr_base_sched
    import vdma_sched_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             wr_vsync,
    input  logic [NBUF-1:0]  buf_mask,
    input  logic [NBUF-1:0]  rd_lock,
    output logic [NBUF-1:0]  wr_curr_point,
    output logic [NBUF-1:0]  last_next_point,
    output logic             frame_done,
    output logic             frame_drop,
    output logic [CNT_W-1:0] frame_cnt,
    output logic [CNT_W-1:0] drop_cnt
);

    sched_state_e     state_q, state_d;
    logic             vs_q, vs_qq, rise;
    logic [NBUF-1:0]  wr_ptr_q, wr_ptr_d;
    logic [NBUF-1:0]  last_q, last_d;
    logic             done_q, done_d;
    logic             drop_q, drop_d;
    logic [CNT_W-1:0] fcnt_q, fcnt_d;
    logic [CNT_W-1:0] dcnt_q, dcnt_d;
    logic [NBUF-1:0]  cand;
    logic [NBUF-1:0]  pick;
    logic             found;

    assign rise = vs_q & ~vs_qq;
    assign cand = buf_mask & ~rd_lock & ~last_q & ~wr_ptr_q;

    buf_pick_rr u_pick (
        .cand  (cand),
        .start (wr_ptr_q),
        .pick  (pick),
        .found (found)
    );

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        last_d   = last_q;
        fcnt_d   = fcnt_q;
        dcnt_d   = dcnt_q;
        done_d   = 1'b0;
        drop_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (rise && en) state_d = ST_WRITE;
            end
            ST_WRITE: begin
                if (!en)       state_d = ST_IDLE;
                else if (rise) state_d = ST_ADVANCE;
            end
            ST_ADVANCE: begin
                // The commit completes even if en fell during this cycle.
                state_d = en ? ST_WRITE : ST_IDLE;
                if (found) begin
                    last_d   = wr_ptr_q;
                    wr_ptr_d = pick;
                    fcnt_d   = fcnt_q + 1'b1;
                    done_d   = 1'b1;
                end else begin
                    drop_d = 1'b1;
                    if (dcnt_q != '1) dcnt_d = dcnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vs_q     <= 1'b0;
            vs_qq    <= 1'b0;
            state_q  <= ST_IDLE;
            wr_ptr_q <= WR_PTR_RST;
            last_q   <= RD_PTR_RST;
            fcnt_q   <= '0;
            dcnt_q   <= '0;
            done_q   <= 1'b0;
            drop_q   <= 1'b0;
        end else begin
            vs_q     <= wr_vsync;
            vs_qq    <= vs_q;
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            last_q   <= last_d;
            fcnt_q   <= fcnt_d;
            dcnt_q   <= dcnt_d;
            done_q   <= done_d;
            drop_q   <= drop_d;
        end
    end

    assign wr_curr_point   = wr_ptr_q;
    assign last_next_point = last_q;
    assign frame_done      = done_q;
    assign frame_drop      = drop_q;
    assign frame_cnt       = fcnt_q;
    assign drop_cnt        = dcnt_q;

endmodule

// File: tb/tb_wr_base_sched.sv
// Directed self-checking bench for wr_base_sched (counters narrowed to 4 bits
// so drop-counter saturation is reachable in a short run).
module tb_wr_base_sched;

    localparam int unsigned CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en = 1'b0;
    logic          wr_vsync = 1'b0;
    logic [4:0]    buf_mask = 5'b11111;
    logic [4:0]    rd_lock = 5'b00010;
    logic [4:0]    wr_curr_point;
    logic [4:0]    last_next_point;
    logic          frame_done;
    logic          frame_drop;
    logic [CW-1:0] frame_cnt;
    logic [CW-1:0] drop_cnt;

    int n_vec = 0;
    int n_err = 0;

    wr_base_sched #(.CNT_W(CW)) dut (
        .clk             (clk),
        .rst             (rst),
        .en              (en),
        .wr_vsync        (wr_vsync),
        .buf_mask        (buf_mask),
        .rd_lock         (rd_lock),
        .wr_curr_point   (wr_curr_point),
        .last_next_point (last_next_point),
        .frame_done      (frame_done),
        .frame_drop      (frame_drop),
        .frame_cnt       (frame_cnt),
        .drop_cnt        (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [4:0] e_wr, input logic [4:0] e_last,
                           input logic [15:0] e_fc, input logic [15:0] e_dc,
                           input logic e_done, input logic e_drop);
        chk({tag, "/wr"},   16'(wr_curr_point),   16'(e_wr));
        chk({tag, "/last"}, 16'(last_next_point), 16'(e_last));
        chk({tag, "/fcnt"}, 16'(frame_cnt),       e_fc);
        chk({tag, "/dcnt"}, 16'(drop_cnt),        e_dc);
        chk({tag, "/done"}, 16'(frame_done),      16'(e_done));
        chk({tag, "/drop"}, 16'(frame_drop),      16'(e_drop));
    endtask

    // Raise vsync at a falling edge, check one cycle after the commit edge,
    // then drop vsync and confirm the pulses last a single cycle.
    task automatic rise_step(input string tag, input logic [4:0] e_wr, input logic [4:0] e_last,
                             input logic [15:0] e_fc, input logic [15:0] e_dc,
                             input logic e_done, input logic e_drop);
        wr_vsync = 1'b1;
        repeat (3) @(negedge clk);
        chk_all(tag, e_wr, e_last, e_fc, e_dc, e_done, e_drop);
        wr_vsync = 1'b0;
        @(negedge clk);
        chk({tag, "/done_end"}, 16'(frame_done), 16'd0);
        chk({tag, "/drop_end"}, 16'(frame_drop), 16'd0);
    endtask

    initial begin
        // Reset with vsync toggling, then release while disabled.
        rst = 1'b1; en = 1'b0;
        repeat (6) begin
            @(negedge clk); wr_vsync = ~wr_vsync;
        end
        @(negedge clk);
        chk_all("reset", 5'b00001, 5'b00010, 16'd0, 16'd0, 1'b0, 1'b0);
        rst = 1'b0;
        repeat (6) begin
            @(negedge clk); wr_vsync = ~wr_vsync;
        end
        wr_vsync = 1'b0;
        repeat (2) @(negedge clk);
        chk_all("idle_dis", 5'b00001, 5'b00010, 16'd0, 16'd0, 1'b0, 1'b0);

        // Steady rotation with the reader holding buffer 1.
        en = 1'b1; buf_mask = 5'b11111; rd_lock = 5'b00010;
        rise_step("rot1", 5'b00001, 5'b00010, 16'd0, 16'd0, 1'b0, 1'b0);
        rise_step("rot2", 5'b00100, 5'b00001, 16'd1, 16'd0, 1'b1, 1'b0);
        rise_step("rot3", 5'b01000, 5'b00100, 16'd2, 16'd0, 1'b1, 1'b0);
        rise_step("rot4", 5'b10000, 5'b01000, 16'd3, 16'd0, 1'b1, 1'b0);

        // Wrap from buffer 4 back to buffer 0.
        rd_lock = 5'b00100;
        rise_step("wrap", 5'b00001, 5'b10000, 16'd4, 16'd0, 1'b1, 1'b0);

        // en falls during ADVANCE: commit still happens, then IDLE.
        wr_vsync = 1'b1;
        repeat (2) @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        chk_all("en_adv", 5'b00010, 5'b00001, 16'd5, 16'd0, 1'b1, 1'b0);
        wr_vsync = 1'b0;
        @(negedge clk);
        en = 1'b1;
        rise_step("en_adv_idle", 5'b00010, 5'b00001, 16'd5, 16'd0, 1'b0, 1'b0);
        rise_step("en_adv_resume", 5'b01000, 5'b00010, 16'd6, 16'd0, 1'b1, 1'b0);

        // en falls in the cycle rise is seen in WRITE: no commit, back to IDLE.
        wr_vsync = 1'b1;
        @(negedge clk);
        en = 1'b0;
        repeat (2) @(negedge clk);
        chk_all("en_rise", 5'b01000, 5'b00010, 16'd6, 16'd0, 1'b0, 1'b0);
        wr_vsync = 1'b0;
        @(negedge clk);
        en = 1'b1;
        rise_step("en_rise_idle", 5'b01000, 5'b00010, 16'd6, 16'd0, 1'b0, 1'b0);
        rise_step("en_rise_resume", 5'b10000, 5'b01000, 16'd7, 16'd0, 1'b1, 1'b0);

        // Reset asserted during the ADVANCE cycle aborts the commit.
        wr_vsync = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b1; wr_vsync = 1'b0;
        @(negedge clk);
        chk_all("rst_adv", 5'b00001, 5'b00010, 16'd0, 16'd0, 1'b0, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        // No free buffer: frame dropped, pointers held, drop count saturates.
        buf_mask = 5'b00111; rd_lock = 5'b00100;
        rise_step("drop_idle", 5'b00001, 5'b00010, 16'd0, 16'd0, 1'b0, 1'b0);
        rise_step("drop1", 5'b00001, 5'b00010, 16'd0, 16'd1, 1'b0, 1'b1);
        for (int i = 2; i <= 18; i++) begin
            rise_step($sformatf("drop%0d", i), 5'b00001, 5'b00010, 16'd0,
                      (i > 15) ? 16'd15 : 16'(i), 1'b0, 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
